// File: rtl/uart_transmitter.sv
// UART transmitter: pops one byte per frame from a first-word-fall-through FIFO
// and sends it LSB first with optional parity and one or two stop bits.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_enable,
  output logic       tx,
  output logic       busy
);
  // state     | meaning
  // ST_IDLE   | line high, waiting for tx_enable and a non-empty FIFO
  // ST_START  | start bit (line low)
  // ST_DATA   | eight data bits, LSB first
  // ST_PARITY | stored parity bit
  // ST_STOP   | stop bit(s), line high

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic          parity_bit;
  logic          bit_done;

  assign bit_done = (cnt == CNT_LAST);

  // Gated by reset so no pop can be issued while the block is held in reset.
  assign fifo_read_enable = reset && (state == ST_IDLE) && tx_enable && !fifo_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shift_reg  <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if (state != ST_IDLE) begin
        cnt <= bit_done ? '0 : cnt + CW'(1);
      end
      case (state)
        ST_IDLE: begin
          if (fifo_read_enable) begin
            shift_reg  <= fifo_data;
            parity_bit <= (^fifo_data) ^ PAR_ODD;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            tx         <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            tx        <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= '0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (PARITY != 0) begin
                tx    <= parity_bit;
                state <= ST_PARITY;
              end else begin
                tx       <= 1'b1;
                stop_idx <= 1'b0;
                state    <= ST_STOP;
              end
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            if (stop_idx == STOP_LAST) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four lanes with different parity/stop settings,
// each fed by a FIFO model and checked frame by frame against an ideal waveform.
module tb_uart_transmitter;
  localparam int NL = 4;
  localparam int C  = 4;

  logic          clk = 1'b0;
  logic [NL-1:0] rst_n;
  logic [NL-1:0] ten;
  logic          fempty [NL];
  logic [7:0]    fdata  [NL];
  logic          fre    [NL];
  logic          tx     [NL];
  logic          busy   [NL];

  logic [7:0] mem  [NL][256];
  logic [7:0] tail [NL];

  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Ideal line waveform of one frame, one sample per clock, first sample in the MSBs.
  function automatic logic [63:0] exp_frame(input logic [7:0] b, input int c,
                                            input int p, input int s);
    logic [63:0] e;
    logic [11:0] lv;
    int nb;
    e = '0;
    lv = '0;
    nb = 0;
    lv[nb] = 1'b0; nb++;
    for (int i = 0; i < 8; i++) begin
      lv[nb] = b[i]; nb++;
    end
    if (p != 0) begin
      lv[nb] = (^b) ^ (p == 2); nb++;
    end
    for (int i = 0; i < s; i++) begin
      lv[nb] = 1'b1; nb++;
    end
    for (int k = 0; k < nb; k++)
      for (int j = 0; j < c; j++)
        e = {e[62:0], lv[k]};
    return e;
  endfunction

  task automatic push(input int ln, input logic [7:0] b);
    mem[ln][tail[ln]] = b;
    tail[ln] = tail[ln] + 8'd1;
  endtask

  for (genvar g = 0; g < NL; g++) begin : lane
    localparam int LP = (g == 1) ? 1 : (g == 2) ? 2 : 0;
    localparam int LS = (g == 3) ? 2 : 1;
    localparam int F  = (9 + ((LP != 0) ? 1 : 0) + LS) * C;

    logic [7:0]  head = '0;
    logic [63:0] cap;
    logic [7:0]  cur;
    bit          idle_chk;
    int rem, bsy, cyc, last_pop, stray, pop_cnt, done_cnt;

    assign fempty[g] = (head == tail[g]);
    assign fdata[g]  = mem[g][head];

    uart_transmitter #(.CLKS_PER_BIT(C), .STOP_BITS(LS), .PARITY(LP)) dut (
      .clk              (clk),
      .reset            (rst_n[g]),
      .tx_enable        (ten[g]),
      .fifo_empty       (fempty[g]),
      .fifo_data        (fdata[g]),
      .fifo_read_enable (fre[g]),
      .tx               (tx[g]),
      .busy             (busy[g])
    );

    initial forever begin
      @(posedge clk);
      if (fre[g]) head <= head + 8'd1;
    end

    initial begin
      rem = 0; bsy = 0; cyc = 0; last_pop = 0; stray = 0;
      pop_cnt = 0; done_cnt = 0; cap = '0; cur = '0; idle_chk = 1'b0;
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n[g]) begin
          rem = 0;
          idle_chk = 1'b0;
        end else if (rem > 0) begin
          cap = {cap[62:0], tx[g]};
          if (busy[g]) bsy++;
          if (fre[g]) stray++;
          rem--;
          if (rem == 0) begin
            chk($sformatf("l%0d_frame_%02h", g, cur), cap, exp_frame(cur, C, LP, LS));
            chk($sformatf("l%0d_busy_len", g), bsy, F);
            chk($sformatf("l%0d_pops_in_frame", g), stray, 0);
            done_cnt++;
            idle_chk = 1'b1;
          end
        end else begin
          if (idle_chk) begin
            chk($sformatf("l%0d_idle_tx", g), tx[g], 1'b1);
            chk($sformatf("l%0d_idle_busy", g), busy[g], 1'b0);
          end
          if (fre[g]) begin
            chk($sformatf("l%0d_pop_enabled", g), ten[g], 1'b1);
            if (idle_chk) chk($sformatf("l%0d_period", g), cyc - last_pop, F + 1);
            cur = mem[g][pop_cnt[7:0]];
            pop_cnt++;
            last_pop = cyc;
            rem = F;
            cap = '0;
            bsy = 0;
            stray = 0;
          end
          idle_chk = 1'b0;
        end
      end
    end
  end

  function automatic int frames_of(input int ln);
    case (ln)
      0:       return lane[0].done_cnt;
      1:       return lane[1].done_cnt;
      2:       return lane[2].done_cnt;
      default: return lane[3].done_cnt;
    endcase
  endfunction

  task automatic wait_frames(input int ln, input int n);
    int budget;
    budget = 5000;
    while (frames_of(ln) < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (budget == 0) chk($sformatf("l%0d_frames_timeout", ln), frames_of(ln), n);
  endtask

  task automatic wait_pop0(input int n);
    int budget;
    budget = 5000;
    while (lane[0].pop_cnt < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (budget == 0) chk("l0_pop_timeout", lane[0].pop_cnt, n);
  endtask

  logic [7:0] rb, rc;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = '0;
    ten     = '0;
    for (int i = 0; i < NL; i++) tail[i] = '0;

    push(0, 8'hA5);
    push(1, 8'hA5);
    push(1, 8'h07);
    push(2, 8'hA5);
    push(3, 8'h3C);
    ten = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx[0], 1'b1);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_pop", fre[0], 1'b0);
    rst_n = '1;
    #1 chk("latency_pop", fre[0], 1'b1);

    wait_frames(0, 1);
    wait_frames(1, 2);
    wait_frames(2, 1);
    wait_frames(3, 1);
    chk("single_pops", lane[0].pop_cnt, 1);

    @(posedge clk); #1;
    push(0, 8'h00);
    push(0, 8'hFF);
    push(0, 8'h55);
    wait_frames(0, 4);
    chk("b2b_pops", lane[0].pop_cnt, 4);
    chk("b2b_empty", fempty[0], 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_end_tx", tx[0], 1'b1);
    chk("b2b_end_busy", busy[0], 1'b0);

    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push(0, 8'($urandom));
    wait_pop0(5);
    repeat (10) @(posedge clk);
    #1 ten[0] = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    chk("gate_pops", lane[0].pop_cnt, 5);
    chk("gate_frames", lane[0].done_cnt, 5);
    chk("gate_busy", busy[0], 1'b0);
    ten[0] = 1'b1;
    #1 chk("resume_pop", fre[0], 1'b1);
    wait_frames(0, 8);

    @(posedge clk); #1;
    rb = 8'($urandom) & 8'hF7;
    rc = 8'($urandom);
    push(0, rb);
    push(0, rc);
    wait_pop0(9);
    repeat (4 * C + 1) @(posedge clk);
    #1 chk("bit3_level", tx[0], rb[3]);
    #1 rst_n[0] = 1'b0;
    #1;
    chk("rst_async_tx", tx[0], 1'b1);
    chk("rst_async_busy", busy[0], 1'b0);
    chk("rst_async_pop", fre[0], 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n[0] = 1'b1;
    wait_frames(0, 9);
    chk("after_rst_pops", lane[0].pop_cnt, 10);

    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      push(0, 8'($urandom));
      for (int ln = 1; ln < NL; ln++)
        if ($urandom_range(0, 1) == 1) push(ln, 8'($urandom));
      ten[0] = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 60)) @(posedge clk);
    end
    @(posedge clk);
    #1 ten = '1;
    for (int ln = 0; ln < NL; ln++)
      wait_frames(ln, int'(tail[ln]) - ((ln == 0) ? 1 : 0));
    repeat (2) @(posedge clk);
    #1;
    for (int ln = 0; ln < NL; ln++) begin
      chk($sformatf("l%0d_drained", ln), fempty[ln], 1'b1);
      chk($sformatf("l%0d_final_busy", ln), busy[ln], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
